smart_wr_guard: RTL and testbench
=================================

// Module: smart_wr_guard
// PURPOSE
//  Write-side guard for the SMART safe (key) area. It sits between the MSP430 core's data-memory
//  write strobes and the RAM, and is the counterpart of the read-data gating monitor.
//  Writes that target [LOW_SAFE..HIGH_SAFE] are suppressed unless the PC is inside trusted code
//  that was entered through its entry point. Violations raise a stretched device reset.
// PARAMETERS
//  SIZE_MEM_ADDR  15       MSB index of mem_addr (bus is SIZE_MEM_ADDR+1 bits)
//  LOW_SAFE       16'h0200 first address of the protected area (inclusive)
//  HIGH_SAFE      16'h021F last address of the protected area (inclusive)
//  LOW_CODE       16'hA000 trusted code entry point and low bound (inclusive)
//  HIGH_CODE      16'hA0FF trusted code high bound (inclusive)
//  RST_CYCLES     4        reset pulse length in mclk cycles (>=1, <=255)
// PORTS
//  mclk           in   1   memory clock, all state on posedge
//  reset_n        in   1   asynchronous active-low reset
//  mem_addr       in   SIZE_MEM_ADDR+1  data-memory address from core
//  mem_cen_i      in   1   chip enable from core, active low
//  mem_wen_i      in   2   byte write enables from core, active low
//  ins_addr       in   16  current instruction address (PC)
//  disable_debug  in   1   high: reset output masked (write blocking stays active)
//  mem_wen_o      out  2   byte write enables to RAM, active low
//  reset          out  1   high: reset the device
//  trusted        out  1   high: FSM is in TRUSTED
//  viol_cnt       out  8   saturating violation counter
// BEHAVIOUR
//  wr_req   = ~mem_cen_i & (mem_wen_i != 2'b11)
//  in_safe  = LOW_SAFE <= mem_addr <= HIGH_SAFE (zero-extend mem_addr to 16 bits)
//  in_code  = LOW_CODE <= ins_addr <= HIGH_CODE
//  FSM states and transitions (registered; reset state IDLE):
//   IDLE    : ins_addr==LOW_CODE -> TRUSTED; in_code & ins_addr!=LOW_CODE -> VIOL
//             (mid-code entry); wr_req & in_safe -> VIOL
//   TRUSTED : ~in_code -> IDLE; writes to the safe area are allowed
//   VIOL    : load rst_cnt=RST_CYCLES-1 and go to RSTING on the next cycle
//   RSTING  : rst_cnt decrements each cycle; at 0 -> IDLE
//  Priority in IDLE: violation beats entry. A safe write in the same cycle as PC==LOW_CODE
//   goes to VIOL, because TRUSTED has not yet been reached.
//  mem_wen_o is combinational, zero latency:
//   - forced to 2'b11 when wr_req & in_safe & state!=TRUSTED
//   - forced to 2'b11 whenever state is VIOL or RSTING
//   - otherwise equals mem_wen_i
//  reset is asserted in VIOL and RSTING, masked by disable_debug. The first reset cycle is the
//   cycle after the offending access. Total reset length is exactly RST_CYCLES cycles.
//  A violation detected during VIOL or RSTING does not restart the counter.
//  viol_cnt increments by 1 on each IDLE->VIOL transition and saturates at 8'hFF.
//  trusted = (state==TRUSTED), registered.
//  Reset values: state IDLE, rst_cnt 0, reset 0, trusted 0, viol_cnt 0.
//   mem_wen_o passes mem_wen_i through (non-safe writes are not blocked).
//  Asserting reset_n mid-pulse aborts the pulse immediately.
// CONFIGURATION
//  SMART_WR_GUARD_LOG_EN defined: adds outputs viol_addr[15:0] and viol_pc[15:0].
//   On each IDLE->VIOL transition they capture the offending mem_addr and ins_addr.
//   They hold their value until the next violation; reset value is 0.
//  SMART_WR_GUARD_LOG_EN undefined: these ports and registers are absent; all other
//   behaviour is unchanged.
// STRUCTURE
//  Shared package/include smart_defs.vh holds the FSM state encoding
//   (IDLE=2'd0, TRUSTED=2'd1, VIOL=2'd2, RSTING=2'd3) and the default safe/code bounds,
//   so the read monitor and this guard agree on them.
//  One sub-module, smart_rst_stretch: loadable down-counter with a busy output, which drives reset.
//  The range compares and the FSM stay in the top module.
// TESTING (default parameters)
//  1. Release reset_n; ins_addr=16'h4000; write 16'h0210, mem_wen_i=2'b00
//     -> mem_wen_o=2'b11 in the same cycle; reset high for 4 cycles starting next cycle;
//     viol_cnt=1.
//  2. PC=16'hA000, then PC=16'hA010 writes 16'h0200 -> write passes (mem_wen_o=2'b00),
//     trusted=1, no reset.
//  3. From IDLE, PC jumps to 16'hA004 (not the entry point) -> reset asserted, viol_cnt
//     increments, trusted stays 0.
//  4. disable_debug=1 plus the scenario-1 write -> mem_wen_o=2'b11, reset stays 0,
//     viol_cnt=1.
//  5. Write 16'h0300 while in IDLE -> mem_wen_o==mem_wen_i; boundary writes at 16'h01FF and
//     16'h0220 pass; writes at 16'h0200 and 16'h021F are blocked.
//  6. Pull reset_n low in the 2nd reset cycle -> reset drops asynchronously, state IDLE,
//     viol_cnt=0. Separately, 300 violations -> viol_cnt holds at 8'hFF.
//     With SMART_WR_GUARD_LOG_EN defined, viol_addr=16'h0210 and viol_pc=16'h4000 after
//     scenario 1.

Source files
------------

// File: rtl/smart_wr_guard_pkg.sv
// smart_wr_guard_pkg: shared FSM encoding and default safe/code bounds for the SMART guards
package smart_wr_guard_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRUSTED = 2'd1;
  localparam logic [1:0] VIOL    = 2'd2;
  localparam logic [1:0] RSTING  = 2'd3;
  localparam logic [15:0] DEF_LOW_SAFE  = 16'h0200;
  localparam logic [15:0] DEF_HIGH_SAFE = 16'h021F;
  localparam logic [15:0] DEF_LOW_CODE  = 16'hA000;
  localparam logic [15:0] DEF_HIGH_CODE = 16'hA0FF;
  function automatic logic in_range(input logic [15:0] v, input logic [15:0] lo, input logic [15:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/smart_rst_stretch.sv
// smart_rst_stretch: loadable down-counter timing the device reset pulse; busy = more than one cycle left
module smart_rst_stretch (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       busy
);
  logic [7:0] cnt;
  // load on request, otherwise count down and park at zero
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= load ? load_val : (cnt != 8'd0 ? cnt - 8'd1 : cnt);
  assign busy = cnt > 8'd1;
endmodule

// File: rtl/smart_wr_guard.sv
// smart_wr_guard: blocks untrusted writes to the SMART safe area and stretches a reset on violation (option SMART_WR_GUARD_LOG_EN)
module smart_wr_guard
  import smart_wr_guard_pkg::*;
#(
  parameter int          SIZE_MEM_ADDR = 15,
  parameter logic [15:0] LOW_SAFE      = DEF_LOW_SAFE,
  parameter logic [15:0] HIGH_SAFE     = DEF_HIGH_SAFE,
  parameter logic [15:0] LOW_CODE      = DEF_LOW_CODE,
  parameter logic [15:0] HIGH_CODE     = DEF_HIGH_CODE,
  parameter int          RST_CYCLES    = 4
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic [SIZE_MEM_ADDR:0] mem_addr,
  input  logic                   mem_cen_i,
  input  logic [1:0]             mem_wen_i,
  input  logic [15:0]            ins_addr,
  input  logic                   disable_debug,
  output logic [1:0]             mem_wen_o,
  output logic                   reset,
  output logic                   trusted,
  output logic [7:0]             viol_cnt
`ifdef SMART_WR_GUARD_LOG_EN
  ,
  output logic [15:0]            viol_addr,
  output logic [15:0]            viol_pc
`endif
);
  logic [15:0] addr16;
  logic        wr_req, in_safe, in_code, entry, bad_wr, new_viol, busy;
  logic [1:0]  state, state_nxt;
  assign addr16   = 16'(mem_addr);
  assign wr_req   = ~mem_cen_i & (mem_wen_i != 2'b11);
  assign in_safe  = in_range(addr16, LOW_SAFE, HIGH_SAFE);
  assign in_code  = in_range(ins_addr, LOW_CODE, HIGH_CODE);
  assign entry    = ins_addr == LOW_CODE;
  assign bad_wr   = wr_req & in_safe;
  // violations win over entry in IDLE; a one-cycle pulse skips RSTING entirely
  always_comb
    state_nxt = state == IDLE    ? ((bad_wr | (in_code & ~entry)) ? VIOL : entry ? TRUSTED : IDLE) :
                state == TRUSTED ? (in_code ? TRUSTED : IDLE) :
                state == VIOL    ? (RST_CYCLES == 1 ? IDLE : RSTING) :
                                   (busy ? RSTING : IDLE);
  assign new_viol = (state == IDLE) & (state_nxt == VIOL);
  // state register and saturating violation counter
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      viol_cnt <= '0;
    end else begin
      state    <= state_nxt;
      viol_cnt <= (new_viol && viol_cnt != 8'hFF) ? viol_cnt + 8'd1 : viol_cnt;
    end
  smart_rst_stretch u_stretch (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .load     (state == VIOL),
    .load_val (8'(RST_CYCLES - 1)),
    .busy     (busy)
  );
  assign mem_wen_o = ((bad_wr & (state != TRUSTED)) | state[1]) ? 2'b11 : mem_wen_i;
  assign reset     = state[1] & ~disable_debug;
  assign trusted   = state == TRUSTED;
`ifdef SMART_WR_GUARD_LOG_EN
  // capture the offending access on each new violation
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) begin
      viol_addr <= '0;
      viol_pc   <= '0;
    end else if (new_viol) begin
      viol_addr <= addr16;
      viol_pc   <= ins_addr;
    end
`endif
endmodule

// File: tb/tb_smart_wr_guard.sv
// tb_smart_wr_guard: vector table plus hand sequences for smart_wr_guard
module tb_smart_wr_guard;
  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem_addr = '0;
  logic        mem_cen_i = 1'b1;
  logic [1:0]  mem_wen_i = 2'b11;
  logic [15:0] ins_addr = 16'h4000;
  logic        disable_debug = 1'b0;
  logic [1:0]  mem_wen_o;
  logic        reset, trusted;
  logic [7:0]  viol_cnt;
`ifdef SMART_WR_GUARD_LOG_EN
  logic [15:0] viol_addr, viol_pc;
`endif
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] addr;
    logic        cen;
    logic [1:0]  wen;
    logic [15:0] pc;
    logic        dd;
    logic [1:0]  ewen;
    logic        erst;
    logic        etr;
    logic [7:0]  evc;
  } vec_t;
  typedef struct {
    logic [1:0] ewen;
    logic       erst;
    logic       etr;
    logic [7:0] evc;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];

  smart_wr_guard dut (
    .mclk          (mclk),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .mem_cen_i     (mem_cen_i),
    .mem_wen_i     (mem_wen_i),
    .ins_addr      (ins_addr),
    .disable_debug (disable_debug),
    .mem_wen_o     (mem_wen_o),
    .reset         (reset),
    .trusted       (trusted),
    .viol_cnt      (viol_cnt)
`ifdef SMART_WR_GUARD_LOG_EN
    ,
    .viol_addr     (viol_addr),
    .viol_pc       (viol_pc)
`endif
  );

  always #5 mclk = ~mclk;

  task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] a, input logic c, input logic [1:0] w, input logic [15:0] pc,
                     input logic dd, input logic [1:0] ewen, input logic erst, input logic etr, input logic [7:0] evc);
    vecs.push_back('{a, c, w, pc, dd, ewen, erst, etr, evc});
  endtask

  task automatic idle(input logic [15:0] pc, input logic dd, input logic erst, input logic etr, input logic [7:0] evc);
    add(16'h0000, 1'b1, 2'b11, pc, dd, 2'b11, erst, etr, evc);
  endtask

  task automatic drive(input logic [15:0] a, input logic c, input logic [1:0] w, input logic [15:0] pc, input logic dd);
    mem_addr = a;
    mem_cen_i = c;
    mem_wen_i = w;
    ins_addr = pc;
    disable_debug = dd;
  endtask

  initial begin
    exp_t e;
    add(16'h0300, 0, 2'b01, 16'h4000, 0, 2'b01, 0, 0, 0);
    idle(16'h4000, 0, 0, 0, 0);
    add(16'h0300, 0, 2'b00, 16'h4000, 0, 2'b00, 0, 0, 0);
    add(16'h01FF, 0, 2'b10, 16'h4000, 0, 2'b10, 0, 0, 0);
    add(16'h0220, 0, 2'b01, 16'h4000, 0, 2'b01, 0, 0, 0);
    add(16'h0210, 0, 2'b00, 16'h4000, 0, 2'b11, 0, 0, 0);
    add(16'h0300, 0, 2'b00, 16'h4000, 0, 2'b11, 1, 0, 1);
    idle(16'h4000, 0, 1, 0, 1);
    idle(16'h4000, 0, 1, 0, 1);
    add(16'h0200, 0, 2'b00, 16'h4000, 0, 2'b11, 1, 0, 1);
    add(16'h0300, 0, 2'b00, 16'h4000, 0, 2'b00, 0, 0, 1);
    idle(16'hA000, 0, 0, 0, 1);
    add(16'h0200, 0, 2'b00, 16'hA010, 0, 2'b00, 0, 1, 1);
    add(16'h021F, 0, 2'b10, 16'hA0FF, 0, 2'b10, 0, 1, 1);
    idle(16'h4000, 0, 0, 1, 1);
    add(16'h021F, 0, 2'b10, 16'h4000, 0, 2'b11, 0, 0, 1);
    idle(16'h4000, 0, 1, 0, 2);
    add(16'h0300, 0, 2'b00, 16'h4000, 1, 2'b11, 0, 0, 2);
    idle(16'h4000, 0, 1, 0, 2);
    idle(16'h4000, 0, 1, 0, 2);
    add(16'h0300, 0, 2'b00, 16'h4000, 0, 2'b00, 0, 0, 2);
    idle(16'hA004, 0, 0, 0, 2);
    for (int k = 0; k < 4; k++) idle(16'h4000, 0, 1, 0, 3);
    idle(16'h4000, 0, 0, 0, 3);
    add(16'h0200, 0, 2'b00, 16'hA000, 0, 2'b11, 0, 0, 3);
    for (int k = 0; k < 4; k++) idle(16'h4000, 0, 1, 0, 4);
    idle(16'h4000, 0, 0, 0, 4);
    add(16'h0210, 0, 2'b00, 16'h4000, 1, 2'b11, 0, 0, 4);
    add(16'h0300, 0, 2'b00, 16'h4000, 1, 2'b11, 0, 0, 5);
    for (int k = 0; k < 3; k++) idle(16'h4000, 1, 0, 0, 5);
    idle(16'h4000, 0, 0, 0, 5);
    add(16'h0210, 1, 2'b00, 16'h4000, 0, 2'b00, 0, 0, 5);
    add(16'h0210, 0, 2'b11, 16'h4000, 0, 2'b11, 0, 0, 5);
    idle(16'hA100, 0, 0, 0, 5);
    idle(16'h9FFF, 0, 0, 0, 5);
    idle(16'h4000, 0, 0, 0, 5);

    drive(16'h0300, 1'b0, 2'b01, 16'h4000, 1'b0);
    repeat (3) @(negedge mclk);
    #1;
    check("rst_wen_o", 0, 16'(mem_wen_o), 16'h0001);
    check("rst_reset", 0, 16'(reset), 16'h0000);
    check("rst_trusted", 0, 16'(trusted), 16'h0000);
    check("rst_viol_cnt", 0, 16'(viol_cnt), 16'h0000);
    @(negedge mclk);
    reset_n = 1'b1;

    for (int i = 1; i < vecs.size(); i++) begin
      @(negedge mclk);
      drive(vecs[i].addr, vecs[i].cen, vecs[i].wen, vecs[i].pc, vecs[i].dd);
      sb.push_back('{vecs[i].ewen, vecs[i].erst, vecs[i].etr, vecs[i].evc});
      #1;
      e = sb.pop_front();
      check("wen_o", i, 16'(mem_wen_o), 16'(e.ewen));
      check("reset", i, 16'(reset), 16'(e.erst));
      check("trusted", i, 16'(trusted), 16'(e.etr));
      check("viol_cnt", i, 16'(viol_cnt), 16'(e.evc));
`ifdef SMART_WR_GUARD_LOG_EN
      if (i == 6) begin
        check("viol_addr", i, viol_addr, 16'h0210);
        check("viol_pc", i, viol_pc, 16'h4000);
      end
`endif
    end

    @(negedge mclk);
    drive(16'h0210, 1'b0, 2'b00, 16'h4000, 1'b0);
    @(negedge mclk);
    drive(16'h0000, 1'b1, 2'b11, 16'h4000, 1'b0);
    #1;
    check("abort_pre1", 0, 16'(reset), 16'h0001);
    @(negedge mclk);
    #1;
    check("abort_pre2", 0, 16'(reset), 16'h0001);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_reset", 0, 16'(reset), 16'h0000);
    check("abort_viol_cnt", 0, 16'(viol_cnt), 16'h0000);
    drive(16'h0300, 1'b0, 2'b00, 16'h4000, 1'b0);
    #1;
    check("abort_idle_wen", 0, 16'(mem_wen_o), 16'h0000);
    @(negedge mclk);
    reset_n = 1'b1;
    drive(16'h0000, 1'b1, 2'b11, 16'h4000, 1'b0);
    @(negedge mclk);
    #1;
    check("abort_after", 0, 16'(reset), 16'h0000);

    for (int k = 0; k < 300; k++) begin
      @(negedge mclk);
      drive(16'h0205, 1'b0, 2'b10, 16'h4000, 1'b0);
      @(negedge mclk);
      drive(16'h0000, 1'b1, 2'b11, 16'h4000, 1'b0);
      repeat (4) @(negedge mclk);
      if (k == 9) begin
        #1;
        check("sat_cnt10", k, 16'(viol_cnt), 16'd10);
      end
    end
    #1;
    check("sat_cnt", 0, 16'(viol_cnt), 16'h00FF);
    check("sat_reset", 0, 16'(reset), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
